// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file slice: FSM encoding, x0 index, address-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_file_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

    localparam int X0_IDX = 0;

    // Smallest w with 2**w >= n; used to size register addresses.
    function automatic int reg_file_aw(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_file_busy_sb.sv
// Pending-write scoreboard: one busy bit per architectural register, two async lookups.
// Latency: set/clear visible one edge after the strobe; lookups are combinational.
// Backpressure: none; strobes arrive pre-qualified by the parent and are always accepted.
//
// Ports:
//   clk, rst_n           clock and synchronous active-high clear of every busy bit
//   iss_vld / iss_addr   qualified issue: mark iss_addr busy
//   wr_vld  / wr_addr    qualified writeback: mark wr_addr not busy
//   lk_addrN / lk_busyN  lookup ports; x0 and out-of-range addresses report 0
module reg_file_busy_sb
    import reg_file_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_vld,
    input  logic [AW-1:0] iss_addr,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] lk_addr1,
    input  logic [AW-1:0] lk_addr2,
    output logic          lk_busy1,
    output logic          lk_busy2
);

    localparam int NSLOT = 1 << AW;

    logic [NREGS-1:0] busy;
    logic [NSLOT-1:0] addr_ok;

    // Static map of addresses that name a real, writable register.
    for (genvar i = 0; i < NSLOT; i++) begin : g_addr_ok
        assign addr_ok[i] = (i != X0_IDX) && (i < NREGS);
    end

    // The issue update comes last so it wins when both strobes hit one entry:
    // the newly issued producer is still outstanding after the older write retires.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy <= '0;
        end else begin
            if (wr_vld) begin
                busy[wr_addr] <= 1'b0;
            end
            if (iss_vld) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        lk_busy1 = 1'b0;
        lk_busy2 = 1'b0;
        if (addr_ok[lk_addr1]) begin
            lk_busy1 = busy[lk_addr1];
        end
        if (addr_ok[lk_addr2]) begin
            lk_busy2 = busy[lk_addr2];
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file (2 async read, 1 sync write) with issue scoreboard; storage zeroed by a post-reset sweep.
// Latency: reads combinational; writes/issues take effect at the next edge; ready after NREGS-1 sweep edges.
// Backpressure: ready=0 during the clear sweep, where writes and issues are dropped, not queued.
//
// Ports:
//   clk, rst_n                 clock; rst_n is a synchronous reset asserted HIGH
//   rd_addrN / rd_dataN        async read; 0 for x0, out-of-range or while sweeping
//   rd_busyN                   pending-write flag of rd_addrN
//   wr_en / wr_addr / wr_data  writeback port
//   iss_en / iss_addr          issue port, marks destination pending
//   ready                      1 once the sweep has finished
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREGS = 8,
    localparam int AW    = reg_file_aw(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             rd_busy1,
    output logic             rd_busy2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic             ready
);

    localparam int         NSLOT    = 1 << AW;
    // One extra bit so the pointer can step past NREGS-1 when NREGS is a power of two.
    localparam logic [AW:0] CLR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CLR_LAST = (AW+1)'(NREGS - 1);

    rf_state_t        state;
    rf_state_t        state_nxt;
    logic             clr_en;
    logic [AW:0]      clr_ptr;
    logic [AW-1:0]    clr_idx;

    logic [WIDTH-1:0] regs [NREGS];
    logic [NSLOT-1:0] addr_ok;

    logic             wr_hit;
    logic             wr_ok;
    logic             iss_ok;
    logic             byp1;
    logic             byp2;
    logic             lk_busy1;
    logic             lk_busy2;

    for (genvar i = 0; i < NSLOT; i++) begin : g_addr_ok
        assign addr_ok[i] = (i != X0_IDX) && (i < NREGS);
    end

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_ptr == CLR_LAST) begin
            state_nxt = ST_RUN;
        end
    end

    always_comb begin
        ready  = (state == ST_RUN);
        clr_en = (state == ST_CLEAR);
    end

    // Entry 0 is never stored to, so the sweep starts at 1.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            clr_ptr <= CLR_ONE;
        end else if (clr_en) begin
            clr_ptr <= clr_ptr + CLR_ONE;
        end
    end

    assign clr_idx = clr_ptr[AW-1:0];

    // ---------------- write / issue qualification ----------------
    assign wr_hit = ready && wr_en && addr_ok[wr_addr];
    assign wr_ok  = wr_hit && !rst_n;
    assign iss_ok = ready && iss_en && addr_ok[iss_addr] && !rst_n;

    // Storage has no reset; the sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (!rst_n && clr_en) begin
            regs[clr_idx] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_file_busy_sb #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_vld  (iss_ok),
        .iss_addr (iss_addr),
        .wr_vld   (wr_ok),
        .wr_addr  (wr_addr),
        .lk_addr1 (rd_addr1),
        .lk_addr2 (rd_addr2),
        .lk_busy1 (lk_busy1),
        .lk_busy2 (lk_busy2)
    );

    // ---------------- read ports ----------------
`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr_hit && (wr_addr == rd_addr1);
    assign byp2 = wr_hit && (wr_addr == rd_addr2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (ready && addr_ok[rd_addr1]) begin
            rd_data1 = byp1 ? wr_data : regs[rd_addr1];
        end
        if (ready && addr_ok[rd_addr2]) begin
            rd_data2 = byp2 ? wr_data : regs[rd_addr2];
        end
    end

    // A forwarded write retires the pending bit in the same cycle it is read.
    assign rd_busy1 = byp1 ? 1'b0 : lk_busy1;
    assign rd_busy2 = byp2 ? 1'b0 : lk_busy2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: 8-entry main instance plus a 6-entry instance for range checks.
// Latency: inputs change 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: n/a.
module tb_reg_file_sb;

    logic       clk;
    logic       rst_n;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       iss_en;
    logic [2:0] iss_addr;

    logic [3:0] rd_data1;
    logic [3:0] rd_data2;
    logic       rd_busy1;
    logic       rd_busy2;
    logic       ready;

    logic [3:0] rd_data1_6;
    logic [3:0] rd_data2_6;
    logic       rd_busy1_6;
    logic       rd_busy2_6;
    logic       ready_6;

    int n_checks = 0;
    int n_pass   = 0;

    reg_file_sb #(.WIDTH(4), .NREGS(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_busy1 (rd_busy1),
        .rd_busy2 (rd_busy2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .ready    (ready)
    );

    reg_file_sb #(.WIDTH(4), .NREGS(6)) u_dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1_6),
        .rd_data2 (rd_data2_6),
        .rd_busy1 (rd_busy1_6),
        .rd_busy2 (rd_busy2_6),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .ready    (ready_6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    // Walk a full clear sweep and check ready rises on exactly the 7th edge.
    task automatic sweep_and_check(input string tag);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check({tag, "_ready"}, 32'(ready), 32'(i == 7));
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr1 = 3'(a);
            rd_addr2 = 3'(7 - a);
            #1;
            check({tag, "_d1"}, 32'(rd_data1), 32'h0);
            check({tag, "_d2"}, 32'(rd_data2), 32'h0);
            check({tag, "_b1"}, 32'(rd_busy1), 32'h0);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;

        // ---- 1: reset, sweep, traffic ignored during CLEAR ----
        tick();
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_busy1", 32'(rd_busy1), 32'h0);
        check("rst_data1", 32'(rd_data1), 32'h0);
        rst_n    = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = 4'hF;
        iss_en   = 1'b1;
        iss_addr = 3'd4;
        rd_addr1 = 3'd3;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("clr_ready", 32'(ready), 32'(i == 7));
            check("clr6_ready", 32'(ready_6), 32'(i >= 5));
            if (i < 7) begin
                check("clr_rd3", 32'(rd_data1), 32'h0);
            end
        end
        idle_inputs();
        check_all_zero("post_clr");
        rd_addr1 = 3'd4;
        #1;
        check("post_clr_busy4", 32'(rd_busy1), 32'h0);

        // ---- 2: basic write and x0 ----
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
        tick();
        idle_inputs();
        rd_addr1 = 3'd3;
        #1;
        check("wr3_data", 32'(rd_data1), 32'hA);
        check("wr3_busy", 32'(rd_busy1), 32'h0);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hF;
        tick();
        idle_inputs();
        rd_addr2 = 3'd0;
        #1;
        check("x0_data", 32'(rd_data2), 32'h0);
        check("x0_busy", 32'(rd_busy2), 32'h0);

        // ---- 3: scoreboard ----
        iss_en = 1'b1; iss_addr = 3'd5;
        tick();
        idle_inputs();
        rd_addr1 = 3'd5;
        #1;
        check("iss5_busy", 32'(rd_busy1), 32'h1);
        check("iss5_data", 32'(rd_data1), 32'h0);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'h7;
        tick();
        idle_inputs();
        #1;
        check("wr5_busy", 32'(rd_busy1), 32'h0);
        check("wr5_data", 32'(rd_data1), 32'h7);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'h3;
        iss_en = 1'b1; iss_addr = 3'd5;
        tick();
        idle_inputs();
        #1;
        check("same_busy", 32'(rd_busy1), 32'h1);
        check("same_data", 32'(rd_data1), 32'h3);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hC;
        iss_en = 1'b1; iss_addr = 3'd6;
        tick();
        idle_inputs();
        rd_addr2 = 3'd6;
        #1;
        check("diff_busy5", 32'(rd_busy1), 32'h0);
        check("diff_data5", 32'(rd_data1), 32'hC);
        check("diff_busy6", 32'(rd_busy2), 32'h1);

        // ---- 4: same-cycle read of a written register ----
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h1;
        tick();
        idle_inputs();
        iss_en = 1'b1; iss_addr = 3'd2;
        tick();
        idle_inputs();
        rd_addr1 = 3'd2;
        rd_addr2 = 3'd3;
        #1;
        check("pre_byp_data", 32'(rd_data1), 32'h1);
        check("pre_byp_busy", 32'(rd_busy1), 32'h1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_data", 32'(rd_data1), 32'h9);
        check("byp_busy", 32'(rd_busy1), 32'h0);
`else
        check("byp_data", 32'(rd_data1), 32'h1);
        check("byp_busy", 32'(rd_busy1), 32'h1);
`endif
        check("byp_other_port", 32'(rd_data2), 32'hA);
        tick();
        idle_inputs();
        #1;
        check("post_byp_data", 32'(rd_data1), 32'h9);
        check("post_byp_busy", 32'(rd_busy1), 32'h0);

        // ---- 5: reset mid-sweep and in RUN ----
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("mid_rst_ready", 32'(ready), 32'h0);
        tick(); tick(); tick();
        check("mid_sweep_ready", 32'(ready), 32'h0);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("resweep_start", 32'(ready), 32'h0);
        sweep_and_check("resweep");
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h5;
        iss_en = 1'b1; iss_addr = 3'd4;
        tick();
        idle_inputs();
        rd_addr1 = 3'd4;
        rd_addr2 = 3'd2;
        #1;
        check("run_busy4", 32'(rd_busy1), 32'h1);
        check("run_data2", 32'(rd_data2), 32'h5);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("run_rst_ready", 32'(ready), 32'h0);
        check("run_rst_busy4", 32'(rd_busy1), 32'h0);
        check("run_rst_data2", 32'(rd_data2), 32'h0);
        sweep_and_check("run_resweep");
        check_all_zero("run_resweep");

        // ---- 6: NREGS=6 out-of-range addresses ----
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'h5;
        iss_en = 1'b1; iss_addr = 3'd6;
        tick();
        idle_inputs();
        rd_addr1 = 3'd6;
        rd_addr2 = 3'd7;
        #1;
        check("n6_d6", 32'(rd_data1_6), 32'h0);
        check("n6_b6", 32'(rd_busy1_6), 32'h0);
        check("n6_d7", 32'(rd_data2_6), 32'h0);
        check("n6_b7", 32'(rd_busy2_6), 32'h0);
        check("n8_b6", 32'(rd_busy1), 32'h1);
        check("n8_d7", 32'(rd_data2), 32'h5);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hB;
        tick();
        idle_inputs();
        iss_en = 1'b1; iss_addr = 3'd5;
        tick();
        idle_inputs();
        rd_addr1 = 3'd5;
        #1;
        check("n6_d5", 32'(rd_data1_6), 32'hB);
        check("n6_b5", 32'(rd_busy1_6), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
